// File: rtl/re_counter.sv
`default_nettype none
// ============================================================================
// Module      : re_counter
// Description : Retriggerable interval counter. Measures CLR-to-CLR period
//               (TOL) and emits a delayed one-cycle restart pulse (R_TR).
// Revision    : 1.0 - initial release
// ============================================================================
module re_counter #(
    parameter int CNT_W       = 16,
    parameter int TRIG_DELAY  = 4,
    parameter int DEFAULT_TOL = 799
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             CLR,
    output logic [CNT_W-1:0] TOL,
    output logic             R_TR
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_TRIG    = CNT_W'(TRIG_DELAY);
    localparam logic [CNT_W-1:0] c_DEF_TOL = CNT_W'(DEFAULT_TOL);

    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;
    logic             r_measured;
    logic [CNT_W-1:0] r_tol;
    logic             r_rtr;
    logic             w_fire;

    assign w_fire = r_armed && (r_cnt == c_TRIG);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_cnt      <= '0;
            r_armed    <= 1'b0;
            r_measured <= 1'b0;
            r_tol      <= c_DEF_TOL;
            r_rtr      <= 1'b0;
        end else if (CLR) begin
            // The first strobe after reset only opens a measurement window.
            if (r_measured) begin
                r_tol <= r_cnt;
            end
            r_cnt      <= '0;
            r_armed    <= 1'b1;
            r_measured <= 1'b1;
            r_rtr      <= 1'b0;
        end else begin
            if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_rtr <= w_fire;
            if (w_fire) begin
                r_armed <= 1'b0;
            end
        end
    end

    assign TOL  = r_tol;
    assign R_TR = r_rtr;

endmodule
`default_nettype wire

// File: tb/tb_re_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_re_counter
// Description : Scoreboard bench for re_counter (default and long-delay builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_re_counter;

    typedef struct {
        int cyc;
        int val;
    } tolExp_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        clr0;
    logic [15:0] tol0;
    logic        rtr0;
    logic        rst1N;
    logic        clr1;
    logic [15:0] tol1;
    logic        rtr1;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    int      pq0[$];
    int      pq1[$];
    tolExp_t tq0[$];
    tolExp_t tq1[$];

    re_counter #(.CNT_W(16), .TRIG_DELAY(4), .DEFAULT_TOL(799)) dut0 (
        .iCLK(clk), .iRST_N(rstN), .CLR(clr0), .TOL(tol0), .R_TR(rtr0)
    );

    re_counter #(.CNT_W(16), .TRIG_DELAY(200), .DEFAULT_TOL(799)) dut1 (
        .iCLK(clk), .iRST_N(rst1N), .CLR(clr1), .TOL(tol1), .R_TR(rtr1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pulses are popped when R_TR is seen, TOL entries at their cycle.
    always @(negedge clk) begin
        int      e;
        tolExp_t t;
        if (rtr0) begin
            checks++;
            if (pq0.size() == 0) begin
                errors++;
                $display("FAIL rtr0_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
                e = pq0.pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL rtr0_timing: pulse at cycle %0d, required %0d", cyc, e);
                end
            end
        end else if (pq0.size() != 0 && pq0[0] < cyc) begin
            checks++;
            errors++;
            e = pq0.pop_front();
            $display("FAIL rtr0_missing: no pulse seen, required at cycle %0d", e);
        end
        if (tq0.size() != 0 && tq0[0].cyc == cyc) begin
            t = tq0.pop_front();
            checks++;
            if (int'(tol0) != t.val) begin
                errors++;
                $display("FAIL tol0 at cycle %0d: got %0d, required %0d", cyc, tol0, t.val);
            end
        end

        if (rtr1) begin
            checks++;
            if (pq1.size() == 0) begin
                errors++;
                $display("FAIL rtr1_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
                e = pq1.pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL rtr1_timing: pulse at cycle %0d, required %0d", cyc, e);
                end
            end
        end else if (pq1.size() != 0 && pq1[0] < cyc) begin
            checks++;
            errors++;
            e = pq1.pop_front();
            $display("FAIL rtr1_missing: no pulse seen, required at cycle %0d", e);
        end
        if (tq1.size() != 0 && tq1[0].cyc == cyc) begin
            t = tq1.pop_front();
            checks++;
            if (int'(tol1) != t.val) begin
                errors++;
                $display("FAIL tol1 at cycle %0d: got %0d, required %0d", cyc, tol1, t.val);
            end
        end
    end

    // All tasks are entered and left on a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expectTol0(input int v);
        tq0.push_back('{cyc + 1, v});
    endtask

    task automatic expectTol1(input int v);
        tq1.push_back('{cyc + 1, v});
    endtask

    task automatic clrPulse0(input bit expPulse, input int expTol);
        int s;
        s = cyc + 1;
        clr0 = 1'b1;
        tq0.push_back('{s, expTol});
        if (expPulse) pq0.push_back(s + 5);
        @(negedge clk);
        clr0 = 1'b0;
    endtask

    task automatic clrPulse1(input bit expPulse, input int expTol);
        int s;
        s = cyc + 1;
        clr1 = 1'b1;
        tq1.push_back('{s, expTol});
        if (expPulse) pq1.push_back(s + 201);
        @(negedge clk);
        clr1 = 1'b0;
    endtask

    initial begin
        int s;
        rstN  = 1'b0;
        rst1N = 1'b0;
        clr0  = 1'b0;
        clr1  = 1'b0;
        @(negedge clk);
        expectTol0(799);
        expectTol1(799);
        idle(3);
        rstN = 1'b1;

        // Idle after reset: TOL holds default, no pulse.
        idle(1000);
        expectTol0(799);
        idle(1);

        // Three strobes 800 apart; first one leaves TOL untouched.
        clrPulse0(1'b1, 799);
        idle(799);
        clrPulse0(1'b1, 799);
        idle(799);
        clrPulse0(1'b1, 799);

        // Period change to 525.
        idle(524);
        clrPulse0(1'b1, 524);
        idle(524);
        clrPulse0(1'b0, 524);

        // Strobes 5 apart land on cnt==4: restart beats the pulse.
        idle(4);
        clrPulse0(1'b0, 4);
        idle(4);
        clrPulse0(1'b1, 4);

        // Long gap saturates the counter.
        idle(69999);
        clrPulse0(1'b1, 65535);

        // CLR held for three edges: 9, then 0, 0; one pulse after release.
        idle(9);
        s = cyc + 1;
        clr0 = 1'b1;
        tq0.push_back('{s, 9});
        tq0.push_back('{s + 1, 0});
        tq0.push_back('{s + 2, 0});
        pq0.push_back(s + 2 + 5);
        idle(3);
        clr0 = 1'b0;
        idle(20);

        // Long-delay build: reset mid-interval cancels the pending pulse.
        rst1N = 1'b1;
        idle(2);
        clrPulse1(1'b0, 799);
        idle(99);
        rst1N = 1'b0;
        expectTol1(799);
        idle(3);
        rst1N = 1'b1;
        idle(300);
        expectTol1(799);
        idle(1);
        clrPulse1(1'b1, 799);
        idle(210);

        checks++;
        if (pq0.size() != 0 || pq1.size() != 0) begin
            errors++;
            $display("FAIL pulse_queue_drain: %0d/%0d left, required 0/0", pq0.size(), pq1.size());
        end
        checks++;
        if (tq0.size() != 0 || tq1.size() != 0) begin
            errors++;
            $display("FAIL tol_queue_drain: %0d/%0d left, required 0/0", tq0.size(), tq1.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
